// File: rtl/skew_input_buffer.sv
// ============================================================================
// Module   : skew_input_buffer
// Purpose  : Input buffer for the activation (west) edge of a systolic array.
//            It holds up to DEPTH column vectors of ROWS elements in a
//            circular memory and streams a burst of `len` vectors into the
//            array. Row r is delayed r cycles relative to row 0, which
//            produces a diagonal wavefront. A burst either consumes its
//            vectors or, in replay mode, leaves them stored for reuse.
// Ports    : clk, rst (async, active-high)
//            wr_en/wr_data -> write port;  wr_ready, overflow (dropped write)
//            start/len/replay -> burst request; start_err (rejected start)
//            busy, done -> burst status; count -> vectors stored
//            o_valid/o_data -> per-row skewed stream, data zero when invalid
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_input_buffer #(
  parameter int ROWS   = 4,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ROWS-1:0][DWIDTH-1:0]    wr_data,
  output logic                           wr_ready,
  output logic                           overflow,
  input  logic                           start,
  input  logic [CNT_W-1:0]               len,
  input  logic                           replay,
  output logic                           start_err,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               count,
  output logic [ROWS-1:0]                o_valid,
  output logic [ROWS-1:0][DWIDTH-1:0]    o_data
);

  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_drw = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] c_depth      = CNT_W'(DEPTH);
  localparam logic [c_drw-1:0] c_drain_init = c_drw'(ROWS - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_stream = 2'd1;
  localparam logic [1:0] c_st_drain  = 2'd2;

  logic [1:0]                     r_state;
  logic [1:0]                     w_state_nxt;
  logic [ROWS-1:0][DWIDTH-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0]                r_wr_ptr;
  logic [c_aw-1:0]                r_rd_ptr;
  logic [c_aw-1:0]                r_offset;   // replay-mode read offset
  logic [CNT_W-1:0]               r_remain;   // reads left in this burst
  logic [c_drw-1:0]               r_drain;    // drain cycles left
  logic                           r_replay;
  logic [CNT_W-1:0]               r_count;
  logic [CNT_W-1:0]               w_count_nxt;
  logic                           r_wr_ready;
  logic                           r_overflow;
  logic                           r_start_err;
  logic                           r_done;
  logic                           w_busy;
  logic                           w_rd_valid;
  logic                           w_accept;
  logic                           w_wr_acc;
  logic                           w_rd_cons;
  logic                           w_last_rd;
  logic [ROWS-1:0][DWIDTH-1:0]    w_rd_vec;

  assign w_accept  = start && (r_state == c_st_idle) && (len != '0) && (len <= r_count);
  assign w_wr_acc  = wr_en && r_wr_ready;
  assign w_rd_cons = w_rd_valid && !r_replay;
  assign w_last_rd = w_rd_valid && (r_remain == CNT_W'(1));

  // Asynchronous read: row 0 sees the vector in the same cycle it is issued.
  assign w_rd_vec = r_mem[r_rd_ptr + r_offset];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_state_nxt = c_st_stream;
      c_st_stream: if (w_last_rd) w_state_nxt = (ROWS > 1) ? c_st_drain : c_st_idle;
      c_st_drain:  if (r_drain == c_drw'(1)) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy     = (r_state != c_st_idle);
    w_rd_valid = (r_state == c_st_stream);
  end

  // ---------------- burst sequencing ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_offset <= '0;
      r_remain <= '0;
      r_drain  <= '0;
      r_replay <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_remain <= len;
        r_offset <= '0;
        r_replay <= replay;
      end else if (w_rd_valid) begin
        r_remain <= r_remain - CNT_W'(1);
        // Replay walks an offset so the base pointer survives the burst.
        if (r_replay) r_offset <= r_offset + c_aw'(1);
        else          r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      if (w_last_rd)                   r_drain <= c_drain_init;
      else if (r_state == c_st_drain)  r_drain <= r_drain - c_drw'(1);
      r_done <= w_busy && (w_state_nxt == c_st_idle);
    end
  end

  // ---------------- write port and occupancy ----------------
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_cons)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_wr_acc && w_rd_cons) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_wr_ready  <= 1'b1;
      r_overflow  <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      r_count     <= w_count_nxt;
      r_wr_ready  <= (w_count_nxt != c_depth);
      r_overflow  <= wr_en && !r_wr_ready;
      r_start_err <= start && (r_state == c_st_idle) && ((len == '0) || (len > r_count));
    end
  end

  // ---------------- triangular skew ----------------
  // Row r passes through r registers. Data is zeroed on entry when invalid,
  // so every stage already carries zero padding.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign o_valid[0] = w_rd_valid;
      assign o_data[0]  = w_rd_valid ? w_rd_vec[0] : '0;
    end else begin : g_delay
      logic [r-1:0]             r_v;
      logic [r-1:0][DWIDTH-1:0] r_d;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= '0;
          r_d <= '0;
        end else begin
          r_v[0] <= w_rd_valid;
          r_d[0] <= w_rd_valid ? w_rd_vec[r] : '0;
          for (int i = 1; i < r; i++) begin
            r_v[i] <= r_v[i-1];
            r_d[i] <= r_d[i-1];
          end
        end
      end
      assign o_valid[r] = r_v[r-1];
      assign o_data[r]  = r_d[r-1];
    end
  end

  assign wr_ready  = r_wr_ready;
  assign overflow  = r_overflow;
  assign start_err = r_start_err;
  assign busy      = w_busy;
  assign done      = r_done;
  assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_skew_input_buffer.sv
// ============================================================================
// Module   : tb_skew_input_buffer
// Purpose  : Self-checking bench for skew_input_buffer (ROWS=4, DEPTH=8).
//            A queue of stored vectors models the buffer; each burst's
//            expected per-row stream is derived from the wavefront timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_skew_input_buffer;

  localparam int ROWS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int VW    = ROWS * DW;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       wr_en;
  logic [ROWS-1:0][DW-1:0]    wr_data;
  logic                       wr_ready;
  logic                       overflow;
  logic                       start;
  logic [CNT_W-1:0]           len;
  logic                       replay;
  logic                       start_err;
  logic                       busy;
  logic                       done;
  logic [CNT_W-1:0]           count;
  logic [ROWS-1:0]            o_valid;
  logic [ROWS-1:0][DW-1:0]    o_data;

  int n_err = 0;
  int n_chk = 0;
  logic [VW-1:0] mq[$];   // vectors currently stored, oldest first

  always #5 clk = ~clk;

  skew_input_buffer #(.ROWS(ROWS), .DWIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .overflow(overflow), .start(start), .len(len), .replay(replay),
    .start_err(start_err), .busy(busy), .done(done), .count(count),
    .o_valid(o_valid), .o_data(o_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_one(input logic [VW-1:0] v);
    bit acc;
    acc = (mq.size() < DEPTH);
    wr_en = 1'b1; wr_data = v;
    tick;
    wr_en = 1'b0;
    if (acc) mq.push_back(v);
    chk("wr_overflow", 64'(overflow), 64'(!acc));
    chk("wr_count",    64'(count),    64'(mq.size()));
    chk("wr_ready",    64'(wr_ready), 64'(mq.size() < DEPTH));
  endtask

  // Request a burst of n vectors. nwr = writes issued on edges T0.., poke = a
  // second start while busy that must be ignored.
  task automatic start_req(input int n, input bit rep, input int nwr, input bit poke);
    int            cnt0;
    int            consumed;
    int            k;
    bit            acc;
    logic [VW-1:0] bv[$];
    logic [VW-1:0] nv;
    logic [VW-1:0] ed;
    logic [ROWS-1:0] ev;
    cnt0 = mq.size();
    start = 1'b1; len = CNT_W'(n); replay = rep;
    if (n == 0 || n > cnt0) begin
      tick;
      start = 1'b0;
      chk("serr_pulse", 64'(start_err), 64'd1);
      chk("serr_busy",  64'(busy),      64'd0);
      chk("serr_count", 64'(count),     64'(cnt0));
      tick;
      chk("serr_clear", 64'(start_err), 64'd0);
      chk("serr_idle",  64'(busy),      64'd0);
      return;
    end
    for (int i = 0; i < n; i++) bv.push_back(mq[i]);
    consumed = 0;
    nv = VW'($urandom);
    wr_en = (nwr > 0); wr_data = nv;
    acc = wr_en && (mq.size() < DEPTH);
    tick;
    start = 1'b0; wr_en = 1'b0;
    if (acc) mq.push_back(nv);
    for (int j = 1; j <= n + ROWS; j++) begin
      ev = '0; ed = '0;
      for (int r = 0; r < ROWS; r++) begin
        k = j - 1 - r;
        if (k >= 0 && k < n) begin
          ev[r] = 1'b1;
          ed[r*DW +: DW] = bv[k][r*DW +: DW];
        end
      end
      chk($sformatf("valid_c%0d", j), 64'(o_valid),   64'(ev));
      chk($sformatf("data_c%0d", j),  64'(o_data),    64'(ed));
      chk($sformatf("busy_c%0d", j),  64'(busy),      64'(j <= n + ROWS - 1));
      chk($sformatf("done_c%0d", j),  64'(done),      64'(j == n + ROWS));
      chk($sformatf("serr_c%0d", j),  64'(start_err), 64'd0);
      chk($sformatf("count_c%0d", j), 64'(count),     64'(mq.size() - consumed));
      if (j < n + ROWS) begin
        nv = VW'($urandom);
        wr_en = (j < nwr); wr_data = nv;
        acc = wr_en && ((mq.size() - consumed) < DEPTH);
        start = poke && (j == 2);
        len = CNT_W'($urandom_range(1, DEPTH));
        tick;
        start = 1'b0; wr_en = 1'b0;
        if (acc) mq.push_back(nv);
        if (!rep && j <= n) consumed++;
      end
    end
    for (int i = 0; i < consumed; i++) void'(mq.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; len = '0; replay = 1'b0;
    tick; tick;
    chk("rst_valid", 64'(o_valid),   64'd0);
    chk("rst_data",  64'(o_data),    64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_count", 64'(count),     64'd0);
    chk("rst_ready", 64'(wr_ready),  64'd1);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_serr",  64'(start_err), 64'd0);
    rst = 1'b0;
    tick;

    // Basic skew: element r of vector k = 16k + r
    for (int kk = 0; kk < 3; kk++) begin
      for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(16 * kk + r);
      wr_one(v);
    end
    start_req(3, 1'b0, 0, 1'b0);

    // Replay then consume the same tile
    for (int kk = 0; kk < 3; kk++) begin
      for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(16 * kk + r);
      wr_one(v);
    end
    start_req(3, 1'b1, 0, 1'b0);
    chk("replay_count", 64'(count), 64'd3);
    start_req(3, 1'b0, 0, 1'b0);
    chk("consume_count", 64'(count), 64'd0);

    // Errors with count = 2, then a start while busy
    wr_one(VW'($urandom));
    wr_one(VW'($urandom));
    start_req(3, 1'b0, 0, 1'b0);
    start_req(0, 1'b0, 0, 1'b0);
    start_req(2, 1'b0, 0, 1'b1);

    // Full / overflow, burst across the pointer wrap
    for (int i = 0; i < 9; i++) wr_one(VW'($urandom));
    start_req(8, 1'b0, 0, 1'b0);

    // Concurrent writes during a consuming burst
    for (int i = 0; i < 4; i++) wr_one(VW'($urandom));
    start_req(4, 1'b0, 4, 1'b0);
    chk("conc_count", 64'(count), 64'd4);
    start_req(4, 1'b0, 0, 1'b0);

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int i = 0; i < nw; i++) wr_one(VW'($urandom));
      start_req($urandom_range(0, mq.size() + 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a burst
    while (mq.size() < 5) wr_one(VW'($urandom));
    start = 1'b1; len = CNT_W'(5); replay = 1'b0;
    tick;
    start = 1'b0;
    tick;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid),  64'd0);
    chk("arst_data",  64'(o_data),   64'd0);
    chk("arst_busy",  64'(busy),     64'd0);
    chk("arst_count", 64'(count),    64'd0);
    chk("arst_ready", 64'(wr_ready), 64'd1);
    mq.delete();
    #1 rst = 1'b0;
    tick;
    start_req(1, 1'b0, 0, 1'b0);
    wr_one(VW'($urandom));
    start_req(1, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
